countdown_timer_sec: RTL and testbench

- Loadable one-digit seconds countdown timer for the board 7-segment display.
- Complements the free-running 1-second up-counter: the start value comes from switches, the count runs down to 0, then holds with a blinking display and a done flag.
- Contains its own prescaler, a 4-state control FSM, a blink divider, and the same active-low digit encoding used by the board 0-9 decoder.

---
 rtl/countdown_timer_sec_if.sv | 12 +
 rtl/countdown_timer_sec.sv | 137 +++++++++++++
 tb/tb_countdown_timer_sec.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_sec_if.sv
// Control/display bundle for the one-digit seconds countdown timer.
// The master drives load/run/din; the timer (slave) drives the segments and done flag.
interface countdown_timer_sec_if;
    logic       load;
    logic       run;
    logic [3:0] din;
    logic [0:6] h;
    logic       done;

    modport master (output load, output run, output din, input h, input done);
    modport slave  (input load, input run, input din, output h, output done);
endinterface

// File: rtl/countdown_timer_sec.sv
// Loadable one-digit seconds countdown timer: prescaler, 4-state control FSM,
// blink divider for the DONE display and active-low 7-segment digit decode.
module countdown_timer_sec #(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic                 clk,
    input  logic                 aclr,
    countdown_timer_sec_if.slave bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      value_q, value_d;
    logic [TW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic            blank_q, blank_d;
    logic            tick;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [0:6] seg_decode(input logic [3:0] v);
        logic [0:6] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign tick = (state_q == S_RUN) && (presc_q == TICK_LAST);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            value_q <= '0;
            presc_q <= '0;
            blink_q <= '0;
            blank_q <= 1'b0;
        end else begin
            value_q <= value_d;
            presc_q <= presc_d;
            blink_q <= blink_d;
            blank_q <= blank_d;
        end
    end

    // Blink counter and blank only live in DONE; every other path leaves them cleared.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        presc_d = presc_q;
        blink_d = '0;
        blank_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                if (bus.load) begin
                    value_d = clamp9(bus.din);
                end else if (bus.run) begin
                    state_d = (value_q != 4'd0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (bus.load) begin
                    state_d = S_IDLE;
                    value_d = clamp9(bus.din);
                    presc_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + TW'(1);
                    if (tick && value_q <= 4'd1) begin
                        value_d = 4'd0;
                        state_d = S_DONE;
                    end else begin
                        if (tick) value_d = value_q - 4'd1;
                        if (!bus.run) state_d = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (bus.load) begin
                    state_d = S_IDLE;
                    value_d = clamp9(bus.din);
                    presc_d = '0;
                end else if (bus.run) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.load) begin
                    state_d = S_IDLE;
                    value_d = clamp9(bus.din);
                    presc_d = '0;
                end else begin
                    blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + BW'(1);
                    blank_d = (blink_q == BLINK_LAST) ? ~blank_q : blank_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.done = (state_q == S_DONE);
        bus.h    = blank_q ? 7'b1111111 : seg_decode(value_q);
    end

endmodule

// File: tb/tb_countdown_timer_sec.sv
// Bench for countdown_timer_sec: directed scenarios plus randomized load/run/reset
// traffic compared against a cycle-level behavioural model of the timer.
module tb_countdown_timer_sec;

    localparam int TD = 4;
    localparam int BD = 3;

    logic clk;
    logic aclr;
    int   n_tests;
    int   n_fail;

    countdown_timer_sec_if bus ();

    countdown_timer_sec #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [0:6] SEG [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    logic [0:6] BLANK = 7'b1111111;

    // Model: mode 0 idle, 1 counting, 2 paused, 3 finished.
    int m_mode;
    int m_val;
    int m_elapsed;
    int m_done_cyc;

    function automatic void model_reset();
        m_mode = 0; m_val = 0; m_elapsed = 0; m_done_cyc = 0;
    endfunction

    function automatic void model_step(input logic ld, input logic rn, input logic [3:0] d);
        if (ld) begin
            m_val = (int'(d) > 9) ? 9 : int'(d);
            m_mode = 0; m_elapsed = 0; m_done_cyc = 0;
        end else begin
            case (m_mode)
                0: begin
                    m_elapsed = 0;
                    if (rn) begin
                        m_mode = (m_val != 0) ? 1 : 3;
                        m_done_cyc = 0;
                    end
                end
                1: begin
                    m_elapsed++;
                    if (m_elapsed == TD) begin
                        m_elapsed = 0;
                        m_val = m_val - 1;
                        if (m_val == 0) begin
                            m_mode = 3; m_done_cyc = 0;
                        end else if (!rn) m_mode = 2;
                    end else if (!rn) m_mode = 2;
                end
                2: if (rn) m_mode = 1;
                default: m_done_cyc++;
            endcase
        end
    endfunction

    function automatic logic [0:6] exp_h();
        if (m_mode == 3 && ((m_done_cyc / BD) % 2) == 1) return BLANK;
        return SEG[m_val];
    endfunction

    function automatic logic exp_done();
        return (m_mode == 3);
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (aclr) model_step(bus.load, bus.run, bus.din);
        else model_reset();
        #1;
    endtask

    task automatic test_reset();
        aclr = 1'b0; bus.load = 1'b0; bus.run = 1'b0; bus.din = 4'd0;
        model_reset();
        repeat (3) cyc();
        n_tests++;
        if (bus.h !== 7'b0000001 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: h=%b done=%b, expected h=0000001 done=0", bus.h, bus.done);
        end
        aclr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_tests++;
            if (bus.h !== 7'b0000001 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: h=%b done=%b, expected h=0000001 done=0", i, bus.h, bus.done);
            end
        end
    endtask

    task automatic test_load_run();
        int ev;
        bus.load = 1'b1; bus.din = 4'd3; bus.run = 1'b0;
        cyc();
        n_tests++;
        if (bus.h !== SEG[3]) begin
            n_fail++;
            $display("FAIL load3: h=%b, expected %b", bus.h, SEG[3]);
        end
        bus.load = 1'b0; bus.run = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            ev = (k <= 12) ? 3 - (k - 1) / TD : 0;
            n_tests++;
            if (bus.h !== SEG[ev] || bus.done !== (k >= 13)) begin
                n_fail++;
                $display("FAIL count_down edge %0d: h=%b done=%b, expected h=%b done=%b",
                         k, bus.h, bus.done, SEG[ev], (k >= 13));
            end
        end
    endtask

    task automatic test_clamp_pause();
        bus.load = 1'b1; bus.din = 4'd12; bus.run = 1'b0;
        cyc();
        n_tests++;
        if (bus.h !== 7'b0000100 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp12: h=%b done=%b, expected h=0000100 done=0", bus.h, bus.done);
        end
        bus.load = 1'b0; bus.run = 1'b1;
        repeat (6) cyc();
        n_tests++;
        if (bus.h !== SEG[8]) begin
            n_fail++;
            $display("FAIL run6: h=%b, expected %b", bus.h, SEG[8]);
        end
        bus.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_tests++;
            if (bus.h !== SEG[8] || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_hold cyc %0d: h=%b done=%b, expected h=%b done=0", i, bus.h, bus.done, SEG[8]);
            end
        end
        bus.run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if (bus.h !== ((i < 2) ? SEG[8] : SEG[7])) begin
                n_fail++;
                $display("FAIL resume cyc %0d: h=%b, expected %b", i, bus.h, (i < 2) ? SEG[8] : SEG[7]);
            end
        end
        bus.run = 1'b0;
        cyc();
    endtask

    task automatic test_done_blink();
        int  guard;
        logic [0:6] eh;
        bus.load = 1'b1; bus.din = 4'd1; bus.run = 1'b0;
        cyc();
        bus.load = 1'b0; bus.run = 1'b1;
        guard = 0;
        do begin
            cyc();
            guard++;
        end while (bus.done !== 1'b1 && guard < 20);
        n_tests++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", bus.done, guard);
        end
        for (int j = 0; j < 12; j++) begin
            eh = (((j / BD) % 2) == 1) ? BLANK : SEG[0];
            n_tests++;
            if (bus.h !== eh || bus.done !== 1'b1) begin
                n_fail++;
                $display("FAIL blink cyc %0d: h=%b done=%b, expected h=%b done=1", j, bus.h, bus.done, eh);
            end
            cyc();
        end
        bus.load = 1'b1; bus.din = 4'd5;
        cyc();
        n_tests++;
        if (bus.h !== 7'b0100100 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reload5: h=%b done=%b, expected h=0100100 done=0", bus.h, bus.done);
        end
        bus.load = 1'b0; bus.run = 1'b0;
        cyc();
        n_tests++;
        if (bus.h !== SEG[5] || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reload: h=%b done=%b, expected h=%b done=0", bus.h, bus.done, SEG[5]);
        end
    endtask

    task automatic test_load_midrun();
        bus.load = 1'b1; bus.din = 4'd7; bus.run = 1'b0;
        cyc();
        bus.load = 1'b0; bus.run = 1'b1;
        repeat (8) cyc();
        n_tests++;
        if (bus.h !== SEG[6]) begin
            n_fail++;
            $display("FAIL at6: h=%b, expected %b", bus.h, SEG[6]);
        end
        bus.load = 1'b1; bus.din = 4'd2;
        cyc();
        n_tests++;
        if (bus.h !== SEG[2] || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_on_tick: h=%b done=%b, expected h=%b done=0", bus.h, bus.done, SEG[2]);
        end
        bus.load = 1'b0;
        repeat (3) cyc();
        n_tests++;
        if (bus.h !== SEG[2]) begin
            n_fail++;
            $display("FAIL rerun: h=%b, expected %b", bus.h, SEG[2]);
        end
        #2;
        aclr = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (bus.h !== 7'b0000001 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: h=%b done=%b, expected h=0000001 done=0", bus.h, bus.done);
        end
        bus.run = 1'b0;
        cyc();
        aclr = 1'b1;
        cyc();
    endtask

    task automatic test_zero_start();
        bus.load = 1'b1; bus.din = 4'd0; bus.run = 1'b0;
        cyc();
        bus.load = 1'b0; bus.run = 1'b1;
        cyc();
        n_tests++;
        if (bus.done !== 1'b1 || bus.h !== 7'b0000001) begin
            n_fail++;
            $display("FAIL zero_start: h=%b done=%b, expected h=0000001 done=1", bus.h, bus.done);
        end
        bus.run = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        aclr = 1'b1; bus.load = 1'b0; bus.run = 1'b0;
        model_reset();
        aclr = 1'b0;
        cyc();
        aclr = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            bus.load = ($urandom_range(0, 39) == 0);
            bus.din  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) bus.run = ~bus.run;
            if ($urandom_range(0, 499) == 0) begin
                #2;
                aclr = 1'b0;
                model_reset();
                #1;
                aclr = 1'b1;
            end
            cyc();
            n_tests++;
            if (bus.h !== exp_h() || bus.done !== exp_done()) begin
                n_fail++;
                $display("FAIL random cyc %0d: h=%b done=%b, expected h=%b done=%b",
                         i, bus.h, bus.done, exp_h(), exp_done());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        aclr = 1'b0;
        bus.load = 1'b0; bus.run = 1'b0; bus.din = 4'd0;
        test_reset();
        test_load_run();
        test_clamp_pause();
        test_done_blink();
        test_load_midrun();
        test_zero_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
